if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage; sits directly upstream of the ID stage. Owns the PC register and drives the
//   instruction SRAM port. Applies branch redirects from ID and honours pipeline stalls. Remembers a
//   redirect that arrives while IF is stalled, so no redirect is ever lost.
//   Produces if_to_id_bus = {ce, pc}, which ID registers alongside the SRAM read data.
// PARAMETERS
//   RESET_PC   32'hBFBF_FFFC   PC held in reset; the first fetched address is RESET_PC+4 = 32'hBFC0_0000
// PORTS
//   clk             in   1             clock; all state updates on posedge
//   resetn          in   1             asynchronous, active-low reset
//   stall           in   `StallBus     stall vector; stall[0]==`Stop freezes PC
//   br_bus          in   `BR_WD        {br_e, br_addr[31:0]} from ID, combinational, same cycle
//   if_to_id_bus    out  `IF_TO_ID_WD  {ce, pc[31:0]}
//   inst_sram_en    out  1             fetch request (== ce)
//   inst_sram_wen   out  4             always 4'b0000
//   inst_sram_addr  out  32            == pc
//   inst_sram_wdata out  32            always 32'b0
// BEHAVIOUR
//   Reset values: pc=RESET_PC, ce=0, br_pend=0, pend_addr=0, state=S_BOOT. Every output derives from these.
//   SRAM is synchronous-read: address at cycle N gives data at N+1. ID pairs that data with its registered copy of pc.
//   FSM states:
//     S_BOOT: ce=0. First clock edge after reset release goes to S_RUN: pc<=RESET_PC+4, ce<=1.
//       Stall is ignored in S_BOOT.
//     S_RUN, stall[0]==`NoStop: pc <= br_e ? br_addr : pc+4. Stay in S_RUN.
//     S_RUN, stall[0]==`Stop: pc and ce hold.
//       If br_e: pend_addr<=br_addr, br_pend<=1, go to S_HOLD_BR. Otherwise go to S_HOLD.
//     S_HOLD: pc/ce hold while stalled.
//       br_e during the stall: capture it and go to S_HOLD_BR.
//       On `NoStop: pc <= br_e ? br_addr : pc+4, go to S_RUN.
//     S_HOLD_BR: pc/ce hold while stalled. A later br_e overwrites pend_addr (newest redirect wins).
//       On `NoStop: pc <= br_e ? br_addr : pend_addr; br_pend<=0; go to S_RUN.
//   Priority on a release cycle: live br_e > pend_addr > pc+4.
//   Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 0). br_addr is taken verbatim; no alignment check.
//   Outputs: inst_sram_en=ce, inst_sram_addr=pc, if_to_id_bus={ce,pc}. All are registered; no comb path from br_bus.
//   Reset mid-operation: asynchronous clear to the reset values. Any pending redirect is discarded.
//   stall[0] asserted continuously: PC frozen indefinitely. The request stays asserted on the same address.
// CONFIGURATION
//   IF_PERF_CNT_EN defined:
//     Adds outputs fetch_cnt[31:0] and stall_cnt[31:0]; both reset to 0.
//     fetch_cnt increments on each PC advance; stall_cnt increments on each cycle with ce=1 and stall[0]==`Stop.
//     Both wrap.
//   IF_PERF_CNT_EN not defined: the ports and counters do not exist. Fetch behaviour is identical either way.
// STRUCTURE
//   lib/defines.vh holds StallBus, BR_WD, IF_TO_ID_WD, Stop/NoStop and new IF_ST_* state encodings (2 bits).
//   One sub-module, if_pc_next: combinational next-PC mux taking (state, stall0, br_e, br_addr, pend_addr, pc).
//     It outputs next_pc and the load enable; the parent holds all flops and the FSM.
// TESTING
//   Reset release, no stall: ce 0 for 1 cycle, then pc=BFC00000, BFC00004, BFC00008 on consecutive cycles.
//   br_e=1, br_addr=BFC00100 with no stall: next pc = BFC00100; sequential fetch resumes at BFC00104.
//   stall[0]=Stop for 3 cycles, br_e=1 (addr BFC00200) in the 1st cycle only:
//     pc frozen; on release pc=BFC00200.
//   Stalled with pending BFC00200, then br_e=1 addr BFC00300 on the release cycle: pc=BFC00300.
//     The pending redirect is cleared.
//   resetn pulled low mid-stall with a pending branch: immediately pc=BFBFFFFC, ce=0; after release pc=BFC00000.
//   pc forced to FFFFFFFC via redirect, no stall: next pc=00000000.
//     With IF_PERF_CNT_EN, fetch_cnt counts each advance.

Source files
------------

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared widths, stall encodings and FSM states for the fetch stage
package if_stage_pkg;

    localparam int STALL_W     = 6;
    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 33;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        IF_ST_BOOT    = 2'd0,
        IF_ST_RUN     = 2'd1,
        IF_ST_HOLD    = 2'd2,
        IF_ST_HOLD_BR = 2'd3
    } if_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bundle: stall/branch inputs, ID bus and instruction SRAM port
interface if_stage_if;
    import if_stage_pkg::*;

    logic [STALL_W-1:0]     stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;

    modport master (
        input  stall, br_bus,
        output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output stall, br_bus,
        input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/if_stage_pc_next.sv
// rtl/if_stage_pc_next.sv - combinational next-PC mux and load enable for the fetch stage
module if_pc_next
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  if_state_e   state,
    input  logic        stall0,
    input  logic        br_e,
    input  logic        br_pend,
    input  logic [31:0] br_addr,
    input  logic [31:0] pend_addr,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        load_en
);
    always_comb begin
        next_pc = pc;
        load_en = 1'b0;
        if (state == IF_ST_BOOT) begin
            load_en = 1'b1;
            next_pc = pc_plus4(RESET_PC);
        end else if (stall0 == NO_STOP) begin
            load_en = 1'b1;
            // A live redirect beats a remembered one, which beats sequential fetch.
            if (br_e)
                next_pc = br_addr;
            else if (state == IF_ST_HOLD_BR && br_pend)
                next_pc = pend_addr;
            else
                next_pc = pc_plus4(pc);
        end
    end
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, redirect/stall FSM, SRAM request
// Optional IF_PERF_CNT_EN adds fetch_cnt/stall_cnt performance counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic        clk,
    input  logic        resetn,
    if_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);
    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        br_pend_q, br_pend_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        stall0;
    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] next_pc;
    logic        load_en;

    assign stall0  = bus.stall[0];
    assign br_e    = bus.br_bus[32];
    assign br_addr = bus.br_bus[31:0];

    if_pc_next #(.RESET_PC(RESET_PC)) u_pc_next (
        .state     (state_q),
        .stall0    (stall0),
        .br_e      (br_e),
        .br_pend   (br_pend_q),
        .br_addr   (br_addr),
        .pend_addr (pend_addr_q),
        .pc        (pc_q),
        .next_pc   (next_pc),
        .load_en   (load_en)
    );

    always_comb begin
        state_d     = state_q;
        ce_d        = ce_q;
        br_pend_d   = br_pend_q;
        pend_addr_d = pend_addr_q;
        pc_d        = load_en ? next_pc : pc_q;
        unique case (state_q)
            IF_ST_BOOT: begin
                ce_d    = 1'b1;
                state_d = IF_ST_RUN;
            end
            IF_ST_RUN, IF_ST_HOLD: begin
                if (stall0 == STOP) begin
                    if (br_e) begin
                        pend_addr_d = br_addr;
                        br_pend_d   = 1'b1;
                        state_d     = IF_ST_HOLD_BR;
                    end else begin
                        state_d     = IF_ST_HOLD;
                    end
                end else begin
                    state_d = IF_ST_RUN;
                end
            end
            IF_ST_HOLD_BR: begin
                if (stall0 == STOP) begin
                    if (br_e) pend_addr_d = br_addr;
                end else begin
                    br_pend_d = 1'b0;
                    state_d   = IF_ST_RUN;
                end
            end
            default: state_d = IF_ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IF_ST_BOOT;
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            br_pend_q   <= 1'b0;
            pend_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            br_pend_q   <= br_pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign bus.if_to_id_bus    = {ce_q, pc_q};
    assign bus.inst_sram_en    = ce_q;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = pc_q;
    assign bus.inst_sram_wdata = 32'h0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (load_en)                   fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (ce_q && stall0 == STOP)    stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage: directed stall/redirect/reset/wrap vectors
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFBF_FFFC;

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        string       name;
    } exp_t;

    logic clk;
    logic resetn;
    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    if_stage_if bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: after every clock edge or reset assertion, check the oldest expectation.
    always @(posedge clk or negedge resetn) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.if_to_id_bus !== {e.ce, e.pc} || bus.inst_sram_en !== e.ce ||
                bus.inst_sram_addr !== e.pc || bus.inst_sram_wen !== 4'b0000 ||
                bus.inst_sram_wdata !== 32'h0) begin
                n_bad++;
                $display("FAIL %s: got ce=%0b pc=%08h en=%0b addr=%08h wen=%04b wdata=%08h, want ce=%0b pc=%08h",
                         e.name, bus.if_to_id_bus[32], bus.if_to_id_bus[31:0], bus.inst_sram_en,
                         bus.inst_sram_addr, bus.inst_sram_wen, bus.inst_sram_wdata, e.ce, e.pc);
            end
        end
    end

    task automatic expect_nx(input logic ce, input logic [31:0] pc, input string name);
        exp_t e;
        e.ce = ce; e.pc = pc; e.name = name;
        exp_q.push_back(e);
    endtask

    // Called at posedge+2: drive inputs, queue the value expected after the next edge.
    task automatic cyc(input logic st, input logic be, input logic [31:0] ba,
                       input logic ce, input logic [31:0] pc, input string name);
        bus.stall  = {{(STALL_W-1){1'b0}}, st};
        bus.br_bus = {be, ba};
        expect_nx(ce, pc, name);
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        resetn = 1'b0;
        bus.stall  = '0;
        bus.br_bus = '0;
        @(posedge clk);
        #2;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, RST_PC, "reset_hold");
        resetn = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0000, "boot_first");
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0004, "seq_1");
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0008, "seq_2");
        cyc(1'b0, 1'b1, 32'hBFC0_0100, 1'b1, 32'hBFC0_0100, "branch_nostall");
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0104, "branch_resume");
        cyc(1'b1, 1'b1, 32'hBFC0_0200, 1'b1, 32'hBFC0_0104, "stall_br_1");
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC0_0104, "stall_2");
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC0_0104, "stall_3");
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0200, "pend_release");
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0204, "pend_after");
        cyc(1'b1, 1'b1, 32'hBFC0_0200, 1'b1, 32'hBFC0_0204, "pend2_cap");
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC0_0204, "pend2_hold");
        cyc(1'b0, 1'b1, 32'hBFC0_0300, 1'b1, 32'hBFC0_0300, "live_beats_pend");
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0304, "live_after");
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC0_0304, "cleared_stall");
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0308, "cleared_release");
        cyc(1'b1, 1'b1, 32'hA000_0010, 1'b1, 32'hBFC0_0308, "newest_cap1");
        cyc(1'b1, 1'b1, 32'hA000_0020, 1'b1, 32'hBFC0_0308, "newest_cap2");
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0020, "newest_wins");
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hA000_0020, "hold_plain");
        cyc(1'b1, 1'b1, 32'hB000_0000, 1'b1, 32'hA000_0020, "hold_then_br");
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hB000_0000, "hold_br_release");
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, "to_top");
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000, "wrap_zero");
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0004, "wrap_next");
        cyc(1'b1, 1'b1, 32'hC000_0000, 1'b1, 32'h0000_0004, "pre_reset_pend");
        #3;
        expect_nx(1'b0, RST_PC, "async_reset");
        resetn = 1'b0;
        @(posedge clk);
        #2;
        cyc(1'b1, 1'b0, 32'h0, 1'b0, RST_PC, "reset_low");
        resetn = 1'b1;
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC0_0000, "boot_ignores_stall");
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC0_0000, "post_reset_stall");
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0004, "pend_discarded");

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
`ifdef IF_PERF_CNT_EN
        n_cmp++;
        if (fetch_cnt !== 32'd2) begin
            n_bad++;
            $display("FAIL fetch_cnt: got %0d want 2", fetch_cnt);
        end
        n_cmp++;
        if (stall_cnt !== 32'd1) begin
            n_bad++;
            $display("FAIL stall_cnt: got %0d want 1", stall_cnt);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
